alu_exec_mc: RTL and testbench

//  Multi-cycle ALU execution unit; consumes the 4-bit alu_ctrl code produced by ALU

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_shift_iter.sv | 47 ++++
 rtl/alu_exec_mc.sv | 109 ++++++++++
 tb/tb_alu_exec_mc.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, alu_ctrl encoding, execution-unit state and response payload.
package alu_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned SHAMT_W = $clog2(XLEN);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } exec_state_e;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            zero;
  } alu_rsp_t;

  function automatic logic is_shift(input logic [3:0] ctrl);
    return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// Iterative one-bit-per-cycle shifter: loads an operand and shift count, then shifts until count runs out.
module alu_shift_iter
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               dir,
  input  logic               arith,
  input  logic [XLEN-1:0]    load_val,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [XLEN-1:0]    shifted_c,
  output logic               done_c
);

  logic [XLEN-1:0]    acc;
  logic [SHAMT_W-1:0] count;
  logic               dir_q;
  logic               arith_q;

  // dir_q=1 selects right shifts; arith_q replicates the sign bit on the way in
  always_comb begin
    shifted_c = {acc[XLEN-2:0], 1'b0};
    if (dir_q) begin
      shifted_c = {arith_q & acc[XLEN-1], acc[XLEN-1:1]};
    end
    done_c = (count == SHAMT_W'(1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc     <= '0;
      count   <= '0;
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
    end else if (start) begin
      acc     <= load_val;
      count   <= shamt;
      dir_q   <= dir;
      arith_q <= arith;
    end else if (count != '0) begin
      acc   <= shifted_c;
      count <= count - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_exec_mc.sv
// Multi-cycle EX-stage ALU: single-cycle logic/arith/compare, iterative shifts, valid/ready on both sides.
module alu_exec_mc
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  exec_state_e        state;
  exec_state_e        state_n;
  alu_rsp_t           rsp_q;
  logic [XLEN-1:0]    alu_c;
  logic [XLEN-1:0]    res_n;
  logic [XLEN-1:0]    shifted_c;
  logic [SHAMT_W-1:0] shamt;
  logic               shift_done_c;
  logic               shift_start;
  logic               load;

  assign shamt  = op_b[SHAMT_W-1:0];
  assign result = rsp_q.result;
  assign zero   = rsp_q.zero;

  // Single-cycle datapath; shifts only land here with shamt=0, so they pass op_a through
  always_comb begin
    alu_c = op_a + op_b;
    case (alu_ctrl)
      ALU_SUB:                   alu_c = op_a - op_b;
      ALU_SLT:                   alu_c = XLEN'($signed(op_a) < $signed(op_b));
      ALU_SLTU:                  alu_c = XLEN'(op_a < op_b);
      ALU_XOR:                   alu_c = op_a ^ op_b;
      ALU_OR:                    alu_c = op_a | op_b;
      ALU_AND:                   alu_c = op_a & op_b;
      ALU_SLL, ALU_SRL, ALU_SRA: alu_c = op_a;
      default:                   alu_c = op_a + op_b;
    endcase
  end

  alu_shift_iter u_shift (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (shift_start),
    .dir       (alu_ctrl != ALU_SLL),
    .arith     (alu_ctrl == ALU_SRA),
    .load_val  (op_a),
    .shamt     (shamt),
    .shifted_c (shifted_c),
    .done_c    (shift_done_c)
  );

  // Next-state and handshake logic; an accept in IDLE or DONE overrides the default transition
  always_comb begin
    state_n     = state;
    in_ready    = 1'b0;
    load        = 1'b0;
    shift_start = 1'b0;
    res_n       = alu_c;
    case (state)
      ST_IDLE: in_ready = 1'b1;
      ST_SHIFT: begin
        if (shift_done_c) begin
          load    = 1'b1;
          res_n   = shifted_c;
          state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        in_ready = out_ready;
        if (out_ready) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (in_valid && in_ready) begin
      if (is_shift(alu_ctrl) && (shamt != '0)) begin
        shift_start = 1'b1;
        state_n     = ST_SHIFT;
      end else begin
        load    = 1'b1;
        state_n = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      rsp_q     <= '0;
    end else begin
      state     <= state_n;
      out_valid <= (state_n == ST_DONE);
      if (load) begin
        rsp_q <= '{result: res_n, zero: (res_n == '0)};
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_mc.sv
// Directed self-checking bench for alu_exec_mc: hand-computed results, latency, backpressure and reset abort.
module tb_alu_exec_mc;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  int checks;
  int errors;

  localparam logic [3:0] C_ADD  = 4'b0000;
  localparam logic [3:0] C_SUB  = 4'b1000;
  localparam logic [3:0] C_SLL  = 4'b0001;
  localparam logic [3:0] C_SLT  = 4'b0010;
  localparam logic [3:0] C_SLTU = 4'b0011;
  localparam logic [3:0] C_XOR  = 4'b0100;
  localparam logic [3:0] C_SRL  = 4'b0101;
  localparam logic [3:0] C_SRA  = 4'b1101;
  localparam logic [3:0] C_OR   = 4'b0110;
  localparam logic [3:0] C_AND  = 4'b0111;

  alu_exec_mc dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op, scramble inputs after accept, wait for out_valid, check latency/result/zero, then drain.
  task automatic run_op(input string tag, input logic [3:0] ctrl, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input logic exp_zero,
                        input int exp_lat);
    int n;
    logic busy_ok;
    busy_ok  = 1'b1;
    alu_ctrl = ctrl;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    op_a     = $urandom;
    op_b     = $urandom;
    alu_ctrl = 4'(C_SUB);
    n = 0;
    while (!out_valid && n < 100) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      step();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    chk({tag, "_busy_in_ready0"}, 32'(busy_ok), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_zero"}, 32'(zero), 32'(exp_zero));
    step();
    chk({tag, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic seen_valid;
    checks    = 0;
    errors    = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    alu_ctrl  = 4'd0;
    op_a      = 32'd0;
    op_b      = 32'd0;
    out_ready = 1'b1;

    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    reset_n = 1'b1;
    step();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);

    run_op("add_ovf", C_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 0);
    run_op("sub_zero", C_SUB, 32'd5, 32'd5, 32'd0, 1'b1, 0);
    run_op("slt_neg", C_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 0);
    run_op("sltu_max", C_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 0);
    run_op("xor", C_XOR, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 1'b0, 0);
    run_op("or", C_OR, 32'h1200_0034, 32'h0056_7800, 32'h1256_7834, 1'b0, 0);
    run_op("sra4", C_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 4);
    run_op("sll0", C_SLL, 32'd1, 32'd0, 32'd1, 1'b0, 0);
    run_op("srl31", C_SRL, 32'h8000_0000, 32'd31, 32'd1, 1'b0, 31);
    run_op("sll_hi_ignored", C_SLL, 32'd3, 32'hFFFF_FFE1, 32'd6, 1'b0, 1);
    run_op("srl_to_zero", C_SRL, 32'h0000_0004, 32'd3, 32'd0, 1'b1, 3);
    run_op("unused_code", 4'b1111, 32'd3, 32'd4, 32'd7, 1'b0, 0);

    // Backpressure: hold out_ready low in DONE, then accept AND back-to-back
    out_ready = 1'b0;
    alu_ctrl  = C_XOR;
    op_a      = 32'hAAAA_0000;
    op_b      = 32'h0000_5555;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_result", result, 32'hAAAA_5555);
      chk("bp_zero", 32'(zero), 32'd0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    alu_ctrl  = C_AND;
    op_a      = 32'hFF00_FF00;
    op_b      = 32'h0F0F_0F0F;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("b2b_out_valid", 32'(out_valid), 32'd1);
    chk("b2b_and_result", result, 32'h0F00_0F00);
    step();
    chk("b2b_drained", 32'(out_valid), 32'd0);

    // Reset in the middle of a long shift must abort with no result
    alu_ctrl = C_SRL;
    op_a     = 32'h8000_0000;
    op_b     = 32'd10;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("mid_shift_in_ready", 32'(in_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_result", result, 32'd0);
    step();
    reset_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (out_valid !== 1'b0) seen_valid = 1'b1;
    end
    chk("abort_no_stale", 32'(seen_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);

    run_op("post_abort_add", C_ADD, 32'd100, 32'hFFFF_FF9C, 32'd0, 1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
